// File: rtl/tetris_pkg.sv
// Shared types and constants for the 4x8 Tetris datapath.
package tetris_pkg;

  localparam int unsigned ROWS    = 8;
  localparam int unsigned COLS    = 4;
  localparam int unsigned BOARD_W = ROWS * COLS;

  typedef logic [BOARD_W-1:0] board_t;

  localparam logic [1:0] PIECE_SINGLE = 2'b00;
  localparam logic [1:0] PIECE_BAR2   = 2'b01;
  localparam logic [1:0] PIECE_SQUARE = 2'b10;
  localparam logic [1:0] PIECE_L      = 2'b11;

  localparam board_t MASK_SINGLE = 32'h0000_0002;
  localparam board_t MASK_BAR2   = 32'h0000_0006;
  localparam board_t MASK_SQUARE = 32'h0000_0066;
  localparam board_t MASK_L      = 32'h0000_0062;

  localparam board_t COL0_MASK = 32'h1111_1111;
  localparam board_t COL3_MASK = 32'h8888_8888;
  localparam board_t ROW7_MASK = 32'hF000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_FALL,
    ST_LAND,
    ST_WAIT_RET,
    ST_OVER
  } state_t;

  // A shift is legal when no cell sits on the edge it would cross and the moved piece hits nothing settled.
  function automatic logic can_move(board_t mask, board_t edge_mask, board_t moved, board_t settled);
    return ((mask & edge_mask) == '0) && ((moved & settled) == '0);
  endfunction

endpackage

// File: rtl/piece_mask_gen.sv
// Piece code to spawn-position board mask.
module piece_mask_gen
  import tetris_pkg::*;
(
  input  logic [1:0] code,
  output board_t     mask_c
);

  always_comb begin
    mask_c = MASK_SINGLE;
    case (code)
      PIECE_SINGLE: mask_c = MASK_SINGLE;
      PIECE_BAR2:   mask_c = MASK_BAR2;
      PIECE_SQUARE: mask_c = MASK_SQUARE;
      PIECE_L:      mask_c = MASK_L;
      default:      mask_c = MASK_SINGLE;
    endcase
  end

endmodule

// File: rtl/piece_drop.sv
// Active-piece engine: spawn, horizontal moves, gravity, landing handshake and board return.
module piece_drop
  import tetris_pkg::*;
#(
  parameter int unsigned DROP_DIV = 4
) (
  input  logic         clka,
  input  logic         rst,
  input  logic         tick,
  input  logic [1:0]   piece_in,
  input  logic         btn_left,
  input  logic         btn_right,
  output logic         land_valid,
  input  logic         land_ready,
  output logic [31:0]  board_out,
  input  logic         ret_valid,
  input  logic [31:0]  board_ret,
  output logic [1:0]   curr_piece,
  output logic [31:0]  display,
  output logic         game_over
);

  localparam int unsigned CNT_W = (DROP_DIV > 1) ? $clog2(DROP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_DIV - 1);

  state_t           state, state_d;
  board_t           board, board_d;
  board_t           mask, mask_d, mask_h;
  board_t           spawn_mask_c;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             land_valid_d;
  board_t           board_out_d;
  logic [1:0]       curr_piece_d;
  board_t           display_d;
  logic             game_over_d;

  piece_mask_gen u_mask_gen (
    .code   (piece_in),
    .mask_c (spawn_mask_c)
  );

  // State and datapath registers
  always_ff @(posedge clka) begin
    if (rst) begin
      state      <= ST_IDLE;
      board      <= '0;
      mask       <= '0;
      cnt        <= '0;
      land_valid <= 1'b0;
      board_out  <= '0;
      curr_piece <= '0;
      display    <= '0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_d;
      board      <= board_d;
      mask       <= mask_d;
      cnt        <= cnt_d;
      land_valid <= land_valid_d;
      board_out  <= board_out_d;
      curr_piece <= curr_piece_d;
      display    <= display_d;
      game_over  <= game_over_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d      = state;
    board_d      = board;
    mask_d       = mask;
    mask_h       = mask;
    cnt_d        = cnt;
    land_valid_d = land_valid;
    board_out_d  = board_out;
    curr_piece_d = curr_piece;
    game_over_d  = game_over;
    // Rendering freezes once the game is over
    display_d    = (state == ST_OVER) ? display : (board | mask);

    case (state)
      ST_IDLE: state_d = ST_SPAWN;

      ST_SPAWN: begin
        curr_piece_d = piece_in;
        mask_d       = spawn_mask_c;
        if ((spawn_mask_c & board) != '0) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
        end else begin
          state_d = ST_FALL;
        end
      end

      ST_FALL: begin
        if (btn_left && !btn_right && can_move(mask, COL0_MASK, mask >> 1, board)) begin
          mask_h = mask >> 1;
        end else if (btn_right && !btn_left && can_move(mask, COL3_MASK, mask << 1, board)) begin
          mask_h = mask << 1;
        end
        mask_d = mask_h;
        // Gravity acts on the position after this cycle's horizontal move
        if (tick) begin
          if (cnt == CNT_LAST) begin
            cnt_d = '0;
            if (can_move(mask_h, ROW7_MASK, mask_h << 4, board)) begin
              mask_d = mask_h << 4;
            end else begin
              state_d      = ST_LAND;
              land_valid_d = 1'b1;
              board_out_d  = board | mask_h;
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end

      ST_LAND: begin
        if (land_ready) begin
          land_valid_d = 1'b0;
          mask_d       = '0;
          state_d      = ST_WAIT_RET;
        end
      end

      ST_WAIT_RET: begin
        if (ret_valid) begin
          board_d = board_ret;
          state_d = ST_SPAWN;
        end
      end

      ST_OVER: state_d = ST_OVER;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piece_drop.sv
// Self-checking bench for piece_drop: directed corner cases plus randomized run against a cell-level model.
module tb_piece_drop;

  logic        clka = 1'b0;
  logic        rst, tick, btn_left, btn_right, land_ready, ret_valid;
  logic [1:0]  piece_in;
  logic [31:0] board_ret;

  logic        lv_a, go_a, lv_b, go_b;
  logic [31:0] bout_a, disp_a, bout_b, disp_b;
  logic [1:0]  cp_a, cp_b;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  piece_drop #(.DROP_DIV(1)) dut_a (
    .clka(clka), .rst(rst), .tick(tick), .piece_in(piece_in),
    .btn_left(btn_left), .btn_right(btn_right),
    .land_valid(lv_a), .land_ready(land_ready), .board_out(bout_a),
    .ret_valid(ret_valid), .board_ret(board_ret),
    .curr_piece(cp_a), .display(disp_a), .game_over(go_a)
  );

  piece_drop #(.DROP_DIV(3)) dut_b (
    .clka(clka), .rst(rst), .tick(tick), .piece_in(piece_in),
    .btn_left(btn_left), .btn_right(btn_right),
    .land_valid(lv_b), .land_ready(land_ready), .board_out(bout_b),
    .ret_valid(ret_valid), .board_ret(board_ret),
    .curr_piece(cp_b), .display(disp_b), .game_over(go_b)
  );

  // ---------------- reference model (piece = shape + row/col offset) ----------------
  localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_LAND = 3, P_WAIT = 4, P_OVER = 5;

  typedef struct {
    int          ph;
    logic [31:0] board;
    logic [1:0]  code;
    int          orow;
    int          ocol;
    bit          live;
    int          cnt;
    logic        lv;
    logic [31:0] bout;
    logic [31:0] disp;
    logic        go;
  } mdl_t;

  // Place a shape at an offset; returns 1 when every cell is on the board and free.
  function automatic bit place(input logic [1:0] code, input int r0, input int c0,
                               input logic [31:0] brd, output logic [31:0] m);
    int rr[4];
    int cc[4];
    int n;
    bit ok;
    case (code)
      2'd0:    begin n = 1; rr = '{0, 0, 0, 0}; cc = '{1, 0, 0, 0}; end
      2'd1:    begin n = 2; rr = '{0, 0, 0, 0}; cc = '{1, 2, 0, 0}; end
      2'd2:    begin n = 4; rr = '{0, 0, 1, 1}; cc = '{1, 2, 1, 2}; end
      default: begin n = 3; rr = '{0, 1, 1, 0}; cc = '{1, 1, 2, 0}; end
    endcase
    m  = '0;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      int r, c;
      r = rr[i] + r0;
      c = cc[i] + c0;
      if (r < 0 || r > 7 || c < 0 || c > 3) ok = 1'b0;
      else begin
        if (brd[4*r+c]) ok = 1'b0;
        m[4*r+c] = 1'b1;
      end
    end
    return ok;
  endfunction

  function automatic mdl_t step(input mdl_t s, input int div, input bit r_st, input bit tk,
                                input bit bl, input bit br, input bit rdy, input bit rv,
                                input logic [31:0] ret, input logic [1:0] pin);
    mdl_t n;
    logic [31:0] cur, tmp;
    int dc;
    n = s;
    if (r_st) begin
      n.ph = P_IDLE; n.board = '0; n.code = '0; n.orow = 0; n.ocol = 0; n.live = 0;
      n.cnt = 0; n.lv = 0; n.bout = '0; n.disp = '0; n.go = 0;
      return n;
    end
    cur = '0;
    if (s.live) void'(place(s.code, s.orow, s.ocol, 32'h0, cur));
    if (s.ph != P_OVER) n.disp = s.board | cur;
    case (s.ph)
      P_IDLE: n.ph = P_SPAWN;
      P_SPAWN: begin
        n.code = pin; n.orow = 0; n.ocol = 0; n.live = 1;
        if (place(pin, 0, 0, s.board, tmp)) n.ph = P_FALL;
        else begin n.ph = P_OVER; n.go = 1; end
      end
      P_FALL: begin
        dc = (bl && !br) ? -1 : (br && !bl) ? 1 : 0;
        if (dc != 0 && place(s.code, s.orow, s.ocol + dc, s.board, tmp)) n.ocol = s.ocol + dc;
        if (tk) begin
          if (s.cnt == div - 1) begin
            n.cnt = 0;
            if (place(s.code, s.orow + 1, n.ocol, s.board, tmp)) n.orow = s.orow + 1;
            else begin
              void'(place(s.code, s.orow, n.ocol, 32'h0, tmp));
              n.ph = P_LAND; n.lv = 1; n.bout = s.board | tmp;
            end
          end else n.cnt = s.cnt + 1;
        end
      end
      P_LAND: if (rdy) begin n.lv = 0; n.live = 0; n.ph = P_WAIT; end
      P_WAIT: if (rv) begin n.board = ret; n.ph = P_SPAWN; end
      default: ;
    endcase
    return n;
  endfunction

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    tick = 0; btn_left = 0; btn_right = 0; land_ready = 0; ret_valid = 0; board_ret = '0;
  endtask

  typedef struct {
    logic        l;
    logic        r;
    logic [31:0] exp_disp;
  } mv_t;

  mv_t  tbl[7];
  mdl_t ma, mb;
  int   over_cnt;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h33};
    tbl[1] = '{1'b1, 1'b0, 32'h33};
    tbl[2] = '{1'b1, 1'b1, 32'h33};
    tbl[3] = '{1'b0, 1'b1, 32'h66};
    tbl[4] = '{1'b0, 1'b1, 32'hCC};
    tbl[5] = '{1'b0, 1'b1, 32'hCC};
    tbl[6] = '{1'b1, 1'b0, 32'h66};

    // Reset values
    idle_inputs();
    piece_in = 2'b00;
    rst = 1;
    cyc(); cyc();
    chk("reset_outputs", {lv_a, bout_a, cp_a, disp_a, go_a}, '0);
    rst = 0;
    cyc(); cyc(); cyc();
    chk("spawn_display", disp_a, 32'h0000_0002);
    chk("spawn_piece", cp_a, 2'b00);

    // Gravity to the floor with one row per tick
    for (int i = 0; i < 7; i++) begin
      tick = 1; cyc(); tick = 0; cyc();
    end
    chk("drop_bottom_display", disp_a, 32'h2000_0000);
    chk("drop_not_landed", lv_a, 1'b0);
    tick = 1; cyc(); tick = 0;
    chk("land_valid", lv_a, 1'b1);
    chk("land_board_out", bout_a, 32'h2000_0000);

    // Backpressure while inputs toggle
    for (int i = 0; i < 5; i++) begin
      tick = i[0]; btn_left = i[1]; btn_right = ~i[0];
      cyc();
      chk("backpressure_hold", {lv_a, bout_a, disp_a}, {1'b1, 32'h2000_0000, 32'h2000_0000});
    end
    idle_inputs();
    land_ready = 1; cyc(); land_ready = 0;
    chk("transfer_drop_valid", lv_a, 1'b0);
    cyc();
    chk("wait_ret_display", disp_a, 32'h0);

    // Returned board blocks the next spawn
    ret_valid = 1; board_ret = 32'h0000_0002; piece_in = 2'b00;
    cyc();
    ret_valid = 0; board_ret = '0;
    chk("over_not_yet", go_a, 1'b0);
    cyc();
    chk("game_over_set", go_a, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick = 1; btn_left = i[0]; btn_right = i[1]; land_ready = 1; ret_valid = 1;
      board_ret = 32'hFFFF_FFFF; piece_in = 2'b11;
      cyc();
      chk("over_frozen", {go_a, lv_a, cp_a, disp_a}, {1'b1, 1'b0, 2'b00, 32'h0000_0002});
    end

    // Horizontal moves on a square
    idle_inputs();
    piece_in = 2'b10;
    rst = 1; cyc(); cyc(); rst = 0;
    cyc(); cyc(); cyc();
    chk("square_spawn", {cp_a, disp_a}, {2'b10, 32'h66});
    for (int i = 0; i < 7; i++) begin
      btn_left = tbl[i].l; btn_right = tbl[i].r;
      cyc();
      btn_left = 0; btn_right = 0;
      cyc();
      chk($sformatf("move_%0d", i), disp_a, tbl[i].exp_disp);
    end

    // Land the square, then reset while land_valid is high
    for (int i = 0; i < 7; i++) begin
      tick = 1; cyc(); tick = 0; cyc();
    end
    chk("square_land", {lv_a, bout_a}, {1'b1, 32'h6600_0000});
    rst = 1; cyc(); rst = 0;
    chk("reset_mid_land", {lv_a, bout_a, cp_a, disp_a, go_a}, '0);
    cyc();
    chk("idle_after_reset", disp_a, 32'h0);
    cyc(); cyc();
    chk("respawn_after_reset", disp_a, 32'h66);

    // Randomized run against the cell-level model, both gravity divisors
    idle_inputs();
    rst = 1;
    ma = step(ma, 1, 1, 0, 0, 0, 0, 0, '0, '0);
    mb = step(mb, 3, 1, 0, 0, 0, 0, 0, '0, '0);
    cyc();
    over_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 399) == 0) || (over_cnt > 15);
      tick       = ($urandom_range(0, 2) == 0);
      btn_left   = ($urandom_range(0, 3) == 0);
      btn_right  = ($urandom_range(0, 3) == 0);
      land_ready = $urandom_range(0, 1);
      ret_valid  = ($urandom_range(0, 2) == 0);
      board_ret  = $urandom & $urandom & $urandom & 32'hFFFF_FF00;
      piece_in   = 2'($urandom_range(0, 3));
      ma = step(ma, 1, rst, tick, btn_left, btn_right, land_ready, ret_valid, board_ret, piece_in);
      mb = step(mb, 3, rst, tick, btn_left, btn_right, land_ready, ret_valid, board_ret, piece_in);
      over_cnt = (ma.go && mb.go) ? over_cnt + 1 : 0;
      cyc();
      chk($sformatf("rand_a_%0d", i), {lv_a, bout_a, cp_a, disp_a, go_a},
          {ma.lv, ma.bout, ma.code, ma.disp, ma.go});
      chk($sformatf("rand_b_%0d", i), {lv_b, bout_b, cp_b, disp_b, go_b},
          {mb.lv, mb.bout, mb.code, mb.disp, mb.go});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
